// File: rtl/image_pkg.sv
// Shared defaults and types for the ROI statistics pipeline.
package image_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int H_ACT_DEF  = 640;
    localparam int V_ACT_DEF  = 480;
    localparam int CNT_W_DEF  = 32;
    localparam int POS_W      = 16;

    typedef struct packed {
        logic [POS_W-1:0] xstart;
        logic [POS_W-1:0] xend;
        logic [POS_W-1:0] ystart;
        logic [POS_W-1:0] yend;
    } roi_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Tracks the raster position of the pixel presented this cycle; iSOF forces
// that pixel to (0,0) and restarts the scan from there.
module pixel_pos_counter
    import image_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDVAL,
    input  logic             iSOF,
    output logic [POS_W-1:0] oX,
    output logic [POS_W-1:0] oY,
    output logic             oFrameStart,
    output logic             oFrameEnd
);

    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             w_last_x;
    logic             w_last_y;

    assign oX          = iSOF ? '0 : r_x;
    assign oY          = iSOF ? '0 : r_y;
    assign w_last_x    = (oX == POS_W'(H_ACT - 1));
    assign w_last_y    = (oY == POS_W'(V_ACT - 1));
    assign oFrameStart = iSOF | (iDVAL & (oX == '0) & (oY == '0));
    assign oFrameEnd   = iDVAL & w_last_x & w_last_y;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_x <= '0;
            r_y <= '0;
        end else if (iDVAL) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : oY + 1'b1;
            end else begin
                r_x <= oX + 1'b1;
                r_y <= oY;
            end
        end else if (iSOF) begin
            r_x <= '0;
            r_y <= '0;
        end
    end

endmodule

// File: rtl/image_roi_stats.sv
// Masks pixels outside a per-frame ROI and accumulates saturating light/dark
// counts and a pixel sum over the ROI, published once per completed frame.
module image_roi_stats
    import image_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                H_ACT  = H_ACT_DEF,
    parameter int                V_ACT  = V_ACT_DEF,
    parameter int                CNT_W  = CNT_W_DEF,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iDVAL,
    input  logic                    iSOF,
    input  logic [DATA_W-1:0]       iDATA,
    input  logic [POS_W-1:0]        iXSTART,
    input  logic [POS_W-1:0]        iXEND,
    input  logic [POS_W-1:0]        iYSTART,
    input  logic [POS_W-1:0]        iYEND,
    input  logic [DATA_W-1:0]       iTHRESH,
    output logic                    oDVAL,
    output logic [DATA_W-1:0]       oDATA,
    output logic                    oINROI,
    output logic [CNT_W-1:0]        oDarkCount,
    output logic [CNT_W-1:0]        oLightCount,
    output logic [CNT_W+DATA_W-1:0] oSum,
    output logic                    oSTATVAL
);

    localparam int SUM_W = CNT_W + DATA_W;

    logic [POS_W-1:0]  w_x;
    logic [POS_W-1:0]  w_y;
    logic              w_fs;
    logic              w_fe;
    roi_t              r_roi;
    roi_t              w_roi;
    logic [DATA_W-1:0] r_thresh;
    logic [DATA_W-1:0] w_thresh;
    logic              w_inroi;
    logic              w_add_light;
    logic              w_add_dark;

    logic [CNT_W-1:0]  r_dark;
    logic [CNT_W-1:0]  r_light;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W:0]    w_dark_ext;
    logic [CNT_W:0]    w_light_ext;
    logic [SUM_W:0]    w_sum_ext;
    logic [CNT_W-1:0]  w_dark_nx;
    logic [CNT_W-1:0]  w_light_nx;
    logic [SUM_W-1:0]  w_sum_nx;

    pixel_pos_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_pos (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iDVAL       (iDVAL),
        .iSOF        (iSOF),
        .oX          (w_x),
        .oY          (w_y),
        .oFrameStart (w_fs),
        .oFrameEnd   (w_fe)
    );

    // The first pixel of a frame already sees the bounds being captured for it.
    assign w_roi    = w_fs ? roi_t'{iXSTART, iXEND, iYSTART, iYEND} : r_roi;
    assign w_thresh = w_fs ? iTHRESH : r_thresh;

    assign w_inroi = (w_x >= w_roi.xstart) && (w_x <= w_roi.xend) &&
                     (w_y >= w_roi.ystart) && (w_y <= w_roi.yend);
    assign w_add_light = iDVAL & w_inroi & (iDATA >= w_thresh);
    assign w_add_dark  = iDVAL & w_inroi & (iDATA < w_thresh);

    // iSOF restarts accumulation from zero before this cycle's pixel is added.
    assign w_dark_ext  = {1'b0, (iSOF ? '0 : r_dark)} + (CNT_W+1)'(w_add_dark);
    assign w_light_ext = {1'b0, (iSOF ? '0 : r_light)} + (CNT_W+1)'(w_add_light);
    assign w_sum_ext   = {1'b0, (iSOF ? '0 : r_sum)} +
                         (SUM_W+1)'((w_add_light | w_add_dark) ? iDATA : '0);

    assign w_dark_nx  = w_dark_ext[CNT_W]  ? '1 : w_dark_ext[CNT_W-1:0];
    assign w_light_nx = w_light_ext[CNT_W] ? '1 : w_light_ext[CNT_W-1:0];
    assign w_sum_nx   = w_sum_ext[SUM_W]   ? '1 : w_sum_ext[SUM_W-1:0];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_roi       <= '0;
            r_thresh    <= '0;
            r_dark      <= '0;
            r_light     <= '0;
            r_sum       <= '0;
            oDVAL       <= 1'b0;
            oDATA       <= '0;
            oINROI      <= 1'b0;
            oDarkCount  <= '0;
            oLightCount <= '0;
            oSum        <= '0;
            oSTATVAL    <= 1'b0;
        end else begin
            oDVAL    <= iDVAL;
            oSTATVAL <= 1'b0;
            if (w_fs) begin
                r_roi    <= w_roi;
                r_thresh <= iTHRESH;
            end
            if (iDVAL) begin
                oDATA  <= w_inroi ? iDATA : FILL;
                oINROI <= w_inroi;
            end
            if (w_fe) begin
                oDarkCount  <= w_dark_nx;
                oLightCount <= w_light_nx;
                oSum        <= w_sum_nx;
                oSTATVAL    <= 1'b1;
                r_dark      <= '0;
                r_light     <= '0;
                r_sum       <= '0;
            end else begin
                r_dark  <= w_dark_nx;
                r_light <= w_light_nx;
                r_sum   <= w_sum_nx;
            end
        end
    end

endmodule

// File: tb/tb_image_roi_stats.sv
// Self-checking bench: two instances (wide and 4-bit counters) against a
// frame-level reference model, plus literal checks of the directed scenarios.
module tb_image_roi_stats;

    localparam int              DW    = 10;
    localparam int              H     = 8;
    localparam int              V     = 4;
    localparam int              CW    = 32;
    localparam int              CWS   = 4;
    localparam logic [DW-1:0]   FILLV = 10'h155;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dval = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] thr = '0;
    logic [15:0]   xs = '0, xe = '0, ys = '0, ye = '0;

    logic             o_dval, o_inroi, o_stat;
    logic [DW-1:0]    o_data;
    logic [CW-1:0]    o_dark, o_light;
    logic [CW+DW-1:0] o_sum;

    logic              s_dval, s_inroi, s_stat;
    logic [DW-1:0]     s_data;
    logic [CWS-1:0]    s_dark, s_light;
    logic [CWS+DW-1:0] s_sum;

    image_roi_stats #(.DATA_W(DW), .H_ACT(H), .V_ACT(V), .CNT_W(CW), .FILL(FILLV)) dut (
        .iCLK(clk), .iRST(rst), .iDVAL(dval), .iSOF(sof), .iDATA(data),
        .iXSTART(xs), .iXEND(xe), .iYSTART(ys), .iYEND(ye), .iTHRESH(thr),
        .oDVAL(o_dval), .oDATA(o_data), .oINROI(o_inroi),
        .oDarkCount(o_dark), .oLightCount(o_light), .oSum(o_sum), .oSTATVAL(o_stat)
    );

    image_roi_stats #(.DATA_W(DW), .H_ACT(H), .V_ACT(V), .CNT_W(CWS), .FILL(FILLV)) dut_s (
        .iCLK(clk), .iRST(rst), .iDVAL(dval), .iSOF(sof), .iDATA(data),
        .iXSTART(xs), .iXEND(xe), .iYSTART(ys), .iYEND(ye), .iTHRESH(thr),
        .oDVAL(s_dval), .oDATA(s_data), .oINROI(s_inroi),
        .oDarkCount(s_dark), .oLightCount(s_light), .oSum(s_sum), .oSTATVAL(s_stat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stat_cnt = 0;
    int roi200_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state: raster position, frame-captured settings, raw sums.
    int            mx = 0, my = 0;
    int            sxs = 0, sxe = 0, sys = 0, sye = 0, sth = 0;
    longint        ad = 0, al = 0, asum = 0;
    bit            e_dval = 0, e_inroi = 0, e_stat = 0;
    logic [DW-1:0] e_data = '0;
    longint        e_dark = 0, e_light = 0, e_sum = 0;

    function automatic logic [63:0] sat(longint v, int w);
        longint mxv;
        mxv = (longint'(1) << w) - 1;
        return (v > mxv) ? mxv : v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_shadow();
        sxs = xs; sxe = xe; sys = ys; sye = ye; sth = thr;
    endtask

    task automatic model_step();
        bit in_roi;
        if (rst) begin
            mx = 0; my = 0; ad = 0; al = 0; asum = 0;
            sxs = 0; sxe = 0; sys = 0; sye = 0; sth = 0;
            e_dval = 0; e_inroi = 0; e_stat = 0; e_data = '0;
            e_dark = 0; e_light = 0; e_sum = 0;
        end else begin
            e_stat = 0;
            e_dval = dval;
            if (sof) begin
                mx = 0; my = 0; ad = 0; al = 0; asum = 0;
                load_shadow();
            end
            if (dval) begin
                if (mx == 0 && my == 0) load_shadow();
                in_roi = (mx >= sxs) && (mx <= sxe) && (my >= sys) && (my <= sye);
                e_inroi = in_roi;
                e_data = in_roi ? data : FILLV;
                if (in_roi) begin
                    if (int'(data) >= sth) al++; else ad++;
                    asum += data;
                end
                if (mx == H - 1 && my == V - 1) begin
                    e_dark = ad; e_light = al; e_sum = asum; e_stat = 1;
                    ad = 0; al = 0; asum = 0; mx = 0; my = 0;
                end else begin
                    mx++;
                    if (mx == H) begin mx = 0; my++; end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("dval", o_dval, e_dval);
            chk("data", o_data, e_data);
            chk("inroi", o_inroi, e_inroi);
            chk("stat", o_stat, e_stat);
            chk("dark", o_dark, sat(e_dark, CW));
            chk("light", o_light, sat(e_light, CW));
            chk("sum", o_sum, sat(e_sum, CW + DW));
            chk("s_data", s_data, e_data);
            chk("s_stat", s_stat, e_stat);
            chk("s_dark", s_dark, sat(e_dark, CWS));
            chk("s_light", s_light, sat(e_light, CWS));
            chk("s_sum", s_sum, sat(e_sum, CWS + DW));
            if (o_stat) stat_cnt++;
            if (o_dval && o_inroi && o_data == 10'd200) roi200_cnt++;
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic s);
        @(posedge clk);
        #1;
        dval = v; data = d; sof = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    endtask

    task automatic set_roi(input int a, input int b, input int c, input int d, input int t);
        xs = 16'(a); xe = 16'(b); ys = 16'(c); ye = 16'(d); thr = DW'(t);
    endtask

    task automatic frame(input logic [DW-1:0] d);
        for (int i = 0; i < H * V; i++) cyc(1'b1, d, 1'b0);
        idle(2);
    endtask

    task automatic lit(string tag, longint dk, longint lt, longint sm, longint sdk, longint slt, longint ssm);
        @(negedge clk);
        chk({tag, "_dark"}, o_dark, dk);
        chk({tag, "_light"}, o_light, lt);
        chk({tag, "_sum"}, o_sum, sm);
        chk({tag, "_s_dark"}, s_dark, sdk);
        chk({tag, "_s_light"}, s_light, slt);
        chk({tag, "_s_sum"}, s_sum, ssm);
    endtask

    initial begin
        int s0, r0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_data", o_data, 0);
        chk("rst_dval", o_dval, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fixed ROI, constant bright pixels, two frames.
        set_roi(2, 5, 1, 2, 100);
        s0 = stat_cnt; r0 = roi200_cnt;
        frame(10'd200);
        frame(10'd200);
        lit("roi8", 0, 8, 1600, 0, 8, 1600);
        chk("roi8_pulses", stat_cnt - s0, 2);
        chk("roi8_hits", roi200_cnt - r0, 16);

        // Gapped valid, values straddling the threshold, full-frame ROI.
        set_roi(0, 7, 0, 3, 100);
        for (int i = 0; i < 2 * H * V; i++) begin
            cyc(1'b1, (i % 4 == 0) ? 10'd99 : 10'd100, 1'b0);
            cyc(1'b0, '0, 1'b0);
            i++;
        end
        idle(2);
        lit("thr", 16, 16, 3184, 15, 15, 3184);

        // ROI change mid-frame at pixel (3,1) applies from the next frame.
        set_roi(0, 7, 0, 3, 100);
        for (int i = 0; i < H * V; i++) begin
            cyc(1'b1, 10'd200, 1'b0);
            if (i == 11) set_roi(2, 5, 1, 2, 100);
        end
        idle(2);
        lit("old_roi", 0, 32, 6400, 0, 15, 6400);
        frame(10'd200);
        lit("new_roi", 0, 8, 1600, 0, 8, 1600);

        // Resync pulse with a pixel at index 17.
        s0 = stat_cnt;
        for (int i = 0; i < 17; i++) cyc(1'b1, 10'd50, 1'b0);
        cyc(1'b1, 10'd200, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b1, 10'd200, 1'b0);
        idle(3);
        chk("sof_nopulse", stat_cnt - s0, 0);
        cyc(1'b1, 10'd200, 1'b0);
        idle(2);
        chk("sof_pulse", stat_cnt - s0, 1);
        lit("sof", 0, 8, 1600, 0, 8, 1600);

        // Inverted column bounds give an empty ROI.
        set_roi(6, 2, 0, 3, 100);
        s0 = stat_cnt;
        frame(10'd200);
        chk("empty_pulse", stat_cnt - s0, 1);
        lit("empty", 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional resyncs and bound changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 20) == 0)
                set_roi($urandom_range(0, 9), $urandom_range(0, 9),
                        $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1023));
            cyc($urandom_range(0, 3) != 0, DW'($urandom_range(0, 1023)), $urandom_range(0, 80) == 0);
        end
        cyc(1'b0, '0, 1'b1);
        idle(1);

        // Saturation with narrow counters.
        set_roi(0, 7, 0, 3, 100);
        frame(10'd1023);
        lit("satur", 0, 32, 32736, 0, 15, 16383);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) cyc(1'b1, 10'd300, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; dval = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        lit("midrst", 0, 0, 0, 0, 0, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_inroi", o_inroi, 0);
        frame(10'd200);
        lit("after_rst", 0, 32, 6400, 0, 15, 6400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_roi_stats.md
IMAGE_ROI_STATS -- requirements
Module: image_roi_stats

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W  10  pixel width
  H_ACT  640  active pixels per line
  V_ACT  480  active lines per frame
  CNT_W  32  statistic counter width
  FILL  0  value output for pixels outside the ROI
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  iCLK  in  1  sole clock, rising edge
  iRST  in  1  synchronous, active-high reset
  iDVAL  in  1  input pixel valid strobe
  iSOF  in  1  start-of-frame resync pulse
  iDATA  in  DATA_W  input pixel
  iXSTART/iXEND  in  16  inclusive ROI column bounds
  iYSTART/iYEND  in  16  inclusive ROI row bounds
  iTHRESH  in  DATA_W  light/dark threshold
  oDVAL  out  1  output pixel valid
  oDATA  out  DATA_W  masked pixel
  oINROI  out  1  output pixel lies inside the ROI
  oDarkCount/oLightCount  out  CNT_W  per-frame ROI pixel counts
  oSum  out  CNT_W+DATA_W  per-frame sum of ROI pixel values
  oSTATVAL  out  1  one-cycle pulse, statistics updated

Function
REQ-003 Position counters X (0..H_ACT-1) and Y (0..V_ACT-1) SHALL advance only on cycles with iDVAL=1; X wraps to 0 and increments Y after H_ACT-1; both wrap to 0 after pixel (H_ACT-1,V_ACT-1).
REQ-004 ROI bounds and iTHRESH SHALL be sampled into shadow registers at frame start (pixel (0,0) accepted, or iSOF); mid-frame changes SHALL take effect from the next frame only.
REQ-005 A pixel SHALL be in the ROI iff XSTART<=X<=XEND and YSTART<=Y<=YEND; XSTART>XEND or YSTART>YEND SHALL give an empty ROI; bounds beyond H_ACT-1/V_ACT-1 SHALL clip naturally.
REQ-006 Pixel path latency SHALL be exactly 1 cycle: oDVAL=iDVAL delayed; oDATA=iDATA if in ROI, else FILL; oINROI registered alongside; oDATA/oINROI hold when oDVAL=0.
REQ-007 An ROI pixel with iDATA>=THRESH SHALL count as light, otherwise dark; each ROI pixel SHALL be added (zero-extended) to the running sum.
REQ-008 Running counts and sum SHALL saturate at all-ones, never wrap.
REQ-009 When pixel (H_ACT-1,V_ACT-1) is accepted, the next cycle SHALL present final counts (including that pixel) on oDarkCount/oLightCount/oSum with oSTATVAL=1 for exactly one cycle; running accumulators SHALL clear in the same cycle.
REQ-010 Statistic outputs SHALL hold their last values between oSTATVAL pulses.
REQ-011 iSOF=1 SHALL zero X, Y and running accumulators without raising oSTATVAL (partial frame discarded); if iDVAL=1 in the same cycle, that pixel SHALL be processed as (0,0) of the new frame.
REQ-012 The block SHALL have no backpressure; every iDVAL pixel is consumed.

Reset
REQ-013 iRST=1 on a rising edge SHALL clear X, Y, accumulators, shadow registers and all outputs to 0 (oDATA to 0, not FILL); reset mid-frame discards the frame, and the first iDVAL after reset is (0,0).
REQ-014 iRST SHALL take priority over iSOF and iDVAL.

Structure
REQ-015 Defaults for DATA_W, H_ACT, V_ACT and CNT_W SHALL be constants in the shared package image_pkg.
REQ-016 X/Y tracking SHALL be a sub-module pixel_pos_counter (inputs iDVAL, iSOF; outputs X, Y, frame-start, frame-end flags).

Verification (H_ACT=8, V_ACT=4, DATA_W=10)
REQ-017 ROI X 2..5, Y 1..2, THRESH=100, all pixels 200, continuous iDVAL -> oDATA=200 on exactly 8 pixels per frame, FILL elsewhere; oLightCount=8, oDarkCount=0, oSum=1600, oSTATVAL once per 32 pixels.
REQ-018 iDVAL toggling 1/0, pixel values 99 and 100 alternating -> counts split at the threshold (100 light, 99 dark), oDVAL mirrors iDVAL 1 cycle later.
REQ-019 ROI changed at pixel (3,1) -> current frame statistics use the old ROI, the next frame the new ROI.
REQ-020 iSOF at pixel 17 together with iDVAL -> no oSTATVAL; that pixel is (0,0); the next oSTATVAL follows 32 pixels later.
REQ-021 XSTART=6, XEND=2 -> every oDATA=FILL, all counts 0, oSTATVAL still pulses.
REQ-022 CNT_W=4, full-frame ROI, 32 pixels all 1023 -> oLightCount=15, oSum saturated at all-ones; iRST mid-frame -> all outputs 0 next cycle.
